// File: rtl/debug_ctrl_report_if.sv
// debug_ctrl_report_if: command, counter and UART-tx signals of the debug controller
interface debug_ctrl_report_if #(
  parameter int NB_DATA  = 8,
  parameter int NB_COUNT = 32
);
  logic [NB_DATA-1:0]  i_rx_data;
  logic                i_rx_done;
  logic                i_halt;
  logic [NB_COUNT-1:0] i_count;
  logic                i_tx_done;
  logic                o_tx_start;
  logic [NB_DATA-1:0]  o_tx_data;
  logic                o_exec_mode;
  logic                o_step;
  logic                o_valid;
  logic                o_busy;
  modport slave (
    input  i_rx_data, i_rx_done, i_halt, i_count, i_tx_done,
    output o_tx_start, o_tx_data, o_exec_mode, o_step, o_valid, o_busy
  );
  modport master (
    output i_rx_data, i_rx_done, i_halt, i_count, i_tx_done,
    input  o_tx_start, o_tx_data, o_exec_mode, o_step, o_valid, o_busy
  );
endinterface

// File: rtl/debug_ctrl_report.sv
// debug_ctrl_report: decodes UART run/step commands and reports the latched cycle count as a framed byte stream
module debug_ctrl_report #(
  parameter int                  NB_DATA  = 8,
  parameter int                  NB_COUNT = 32,
  parameter logic [NB_DATA-1:0]  CMD_CONT = 8'h63,
  parameter logic [NB_DATA-1:0]  CMD_STEP = 8'h73,
  parameter logic [NB_DATA-1:0]  HEADER   = 8'hA5
) (
  input logic                i_clk,
  input logic                i_reset,
  debug_ctrl_report_if.slave bus
);
  localparam int N  = NB_COUNT / NB_DATA;
  localparam int NI = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_SEND_HDR, S_SEND_BYTE, S_WAIT, S_HALTED} state_t;
  state_t              state;
  logic [NB_COUNT-1:0] sh;
  logic [NB_COUNT-1:0] sh_nx;
  logic [NI-1:0]       idx;
  logic                hdr;
  logic                late;
  logic                tx_start;
  logic [NB_DATA-1:0]  tx_data;
  logic                exec_mode;
  logic                step;
  logic                valid;
  logic                busy;
  logic                is_cont;
  logic                is_step;
  assign sh_nx   = sh >> NB_DATA;
  assign is_cont = bus.i_rx_done && bus.i_rx_data == CMD_CONT;
  assign is_step = bus.i_rx_done && bus.i_rx_data == CMD_STEP;
  assign bus.o_tx_start  = tx_start;
  assign bus.o_tx_data   = tx_data;
  assign bus.o_exec_mode = exec_mode;
  assign bus.o_step      = step;
  assign bus.o_valid     = valid;
  assign bus.o_busy      = busy;
  // sh holds the latched count and shifts right one byte per sent byte, so the low byte is always next
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= S_IDLE;
      sh        <= '0;
      idx       <= '0;
      hdr       <= 1'b0;
      late      <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      exec_mode <= 1'b0;
      step      <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((is_cont || is_step) && bus.i_halt) begin
            sh       <= bus.i_count;
            state    <= S_SEND_HDR;
            tx_start <= 1'b1;
            tx_data  <= HEADER;
            busy     <= 1'b1;
          end else if (is_cont) begin
            state     <= S_RUN;
            exec_mode <= 1'b0;
            valid     <= 1'b1;
          end else if (is_step) begin
            state     <= S_STEP;
            exec_mode <= 1'b1;
            step      <= 1'b1;
            valid     <= 1'b1;
          end
        end
        S_STEP: begin
          // the counter only reflects the step one cycle later, so the latch is deferred into SEND_HDR
          step     <= 1'b0;
          valid    <= 1'b0;
          late     <= 1'b1;
          state    <= S_SEND_HDR;
          tx_start <= 1'b1;
          tx_data  <= HEADER;
          busy     <= 1'b1;
        end
        S_RUN: begin
          if (bus.i_halt) begin
            sh       <= bus.i_count;
            valid    <= 1'b0;
            state    <= S_SEND_HDR;
            tx_start <= 1'b1;
            tx_data  <= HEADER;
            busy     <= 1'b1;
          end
        end
        S_SEND_HDR: begin
          tx_start <= 1'b0;
          hdr      <= 1'b1;
          late     <= 1'b0;
          state    <= S_WAIT;
          if (late) sh <= bus.i_count;
        end
        S_SEND_BYTE: begin
          tx_start <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_tx_done) begin
            if (hdr) begin
              hdr      <= 1'b0;
              tx_data  <= sh[NB_DATA-1:0];
              tx_start <= 1'b1;
              state    <= S_SEND_BYTE;
            end else if (idx != NI'(N - 1)) begin
              idx      <= idx + 1'b1;
              sh       <= sh_nx;
              tx_data  <= sh_nx[NB_DATA-1:0];
              tx_start <= 1'b1;
              state    <= S_SEND_BYTE;
            end else begin
              idx   <= '0;
              busy  <= 1'b0;
              state <= bus.i_halt ? S_HALTED : S_IDLE;
            end
          end
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_ctrl_report.sv
// tb_debug_ctrl_report: directed checks of command decode, step/run control and report framing
module tb_debug_ctrl_report;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  debug_ctrl_report_if bus ();
  debug_ctrl_report dut (.i_clk(clk), .i_reset(rst), .bus(bus.slave));
  logic [31:0] model_cnt;
  logic [31:0] cnt_set = '0;
  logic        use_model = 1'b0;
  logic        auto_done = 1'b0;
  logic        spur_done = 1'b0;
  int          dly = 1;
  int          dcnt = 0;
  logic [7:0]  q[$];
  logic [7:0]  cur = '0;
  int          n_step = 0, n_valid = 0, n_em = 0, n_active = 0, n_unstable = 0;
  int          n_chk = 0, n_pass = 0;
  assign bus.i_count   = use_model ? model_cnt : cnt_set;
  assign bus.i_tx_done = auto_done | spur_done;
  // counter stand-in: advances once per step pulse
  always @(posedge clk or posedge rst)
    if (rst) model_cnt <= 32'd1;
    else if (bus.o_step) model_cnt <= model_cnt + 32'd1;
  // UART-tx stand-in and output monitor
  always @(negedge clk) begin
    if (bus.o_tx_start) begin
      q.push_back(bus.o_tx_data);
      cur       <= bus.o_tx_data;
      dcnt      <= dly;
      auto_done <= 1'b0;
    end else begin
      if (bus.o_busy && bus.o_tx_data != cur) n_unstable++;
      auto_done <= (dcnt == 1);
      if (dcnt != 0) dcnt <= dcnt - 1;
    end
    if (bus.o_step) begin
      n_step++;
      if (!bus.o_exec_mode) n_em++;
    end
    if (bus.o_valid) n_valid++;
    if (outs() != 0) n_active++;
  end
  function automatic logic [31:0] outs();
    return {19'd0, bus.o_tx_start, bus.o_exec_mode, bus.o_step, bus.o_valid, bus.o_busy, bus.o_tx_data};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic chk_frame(input string tag, input int base, input logic [31:0] c);
    logic [39:0] f = {c, 8'hA5};
    chk({tag, "_len"}, 32'(q.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      chk({tag, "_byte"}, (base + i < q.size()) ? 32'(q[base+i]) : 32'hFFFF_FFFF, 32'(f[i*8 +: 8]));
  endtask
  task automatic rx(input logic [7:0] b);
    @(negedge clk);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
  endtask
  task automatic wait_frame(input int base, input int budget);
    int k = 0;
    while (!(q.size() >= base + 5 && !bus.o_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("frame_timeout", 32'd0, 32'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_rx_done = 1'b0;
    bus.i_halt = 1'b0;
    spur_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    int base, s0, v0, e0, a0, u0, k;
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;
    bus.i_halt    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);
    rst = 1'b0;
    use_model = 1'b1;
    base = q.size(); s0 = n_step; v0 = n_valid; e0 = n_em;
    rx(8'h73);
    wait_frame(base, 400);
    chk("step_pulses", 32'(n_step - s0), 32'd1);
    chk("step_valid_cycles", 32'(n_valid - v0), 32'd1);
    chk("step_exec_mode", 32'(n_em - e0), 32'd0);
    chk_frame("step", base, 32'd2);
    chk("step_busy", 32'(bus.o_busy), 32'd0);
    do_reset();
    use_model = 1'b0;
    cnt_set = 32'h1234_5678;
    base = q.size();
    rx(8'h63);
    repeat (25) @(negedge clk);
    s0 = n_step;
    rx(8'h73);
    repeat (25) @(negedge clk);
    chk("run_valid", 32'(bus.o_valid), 32'd1);
    chk("run_mode", 32'(bus.o_exec_mode), 32'd0);
    chk("run_drop_rx", 32'(n_step - s0), 32'd0);
    bus.i_halt = 1'b1;
    @(negedge clk);
    cnt_set = 32'hDEAD_BEEF;
    chk("halt_valid", 32'(bus.o_valid), 32'd0);
    chk("halt_busy", 32'(bus.o_busy), 32'd1);
    wait_frame(base, 400);
    chk_frame("cont", base, 32'h1234_5678);
    rx(8'h63);
    repeat (20) @(negedge clk);
    chk("halted_valid", 32'(bus.o_valid), 32'd0);
    chk("halted_tx", 32'(q.size() - base), 32'd5);
    do_reset();
    a0 = n_active;
    rx(8'h41);
    repeat (20) @(negedge clk);
    chk("unknown_active", 32'(n_active - a0), 32'd0);
    use_model = 1'b1;
    dly = 12;
    base = q.size();
    @(negedge clk) spur_done = 1'b1;
    @(negedge clk) spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("spur_idle", 32'({bus.o_busy, 8'(q.size() - base)}), 32'd0);
    u0 = n_unstable;
    rx(8'h73);
    repeat (20) @(negedge clk);
    rx(8'h63);
    wait_frame(base, 1000);
    repeat (20) @(negedge clk);
    chk("slow_starts", 32'(q.size() - base), 32'd5);
    chk("slow_stable", 32'(n_unstable - u0), 32'd0);
    chk("busy_drop_rx", 32'(bus.o_valid), 32'd0);
    chk_frame("slow", base, 32'd2);
    dly = 1;
    do_reset();
    use_model = 1'b0;
    cnt_set = 32'd7;
    bus.i_halt = 1'b1;
    base = q.size(); s0 = n_step; v0 = n_valid;
    rx(8'h73);
    wait_frame(base, 400);
    chk("halt_set_step", 32'(n_step - s0), 32'd0);
    chk("halt_set_valid", 32'(n_valid - v0), 32'd0);
    chk_frame("halt_set", base, 32'd7);
    rx(8'h73);
    repeat (20) @(negedge clk);
    chk("halt_set_ignored", 32'(q.size() - base), 32'd5);
    do_reset();
    use_model = 1'b1;
    dly = 0;
    base = q.size();
    rx(8'h73);
    repeat (100) @(negedge clk);
    chk("hold_bytes", 32'(q.size() - base), 32'd1);
    chk("hold_busy", 32'(bus.o_busy), 32'd1);
    chk("hold_data", 32'(bus.o_tx_data), 32'hA5);
    do_reset();
    dly = 3;
    base = q.size();
    rx(8'h73);
    k = 0;
    while (q.size() < base + 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("midreset_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    #1;
    chk("midreset_outs", outs(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = q.size();
    rx(8'h73);
    wait_frame(base, 400);
    repeat (5) @(negedge clk);
    chk_frame("after_reset", base, 32'd2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
